// File: rtl/fft_peak_analyzer_if.sv
// fft_peak_analyzer_if: FFT bin bus into the peak analyzer plus its result outputs.
// master drives fft_valid/fft_d0..fft_d15; slave (analyzer) drives done/freq/busy/drop.
interface fft_peak_analyzer_if #(
  parameter int DW = 16
);
  logic          fft_valid;
  logic [2*DW-1:0] fft_d0;
  logic [2*DW-1:0] fft_d1;
  logic [2*DW-1:0] fft_d2;
  logic [2*DW-1:0] fft_d3;
  logic [2*DW-1:0] fft_d4;
  logic [2*DW-1:0] fft_d5;
  logic [2*DW-1:0] fft_d6;
  logic [2*DW-1:0] fft_d7;
  logic [2*DW-1:0] fft_d8;
  logic [2*DW-1:0] fft_d9;
  logic [2*DW-1:0] fft_d10;
  logic [2*DW-1:0] fft_d11;
  logic [2*DW-1:0] fft_d12;
  logic [2*DW-1:0] fft_d13;
  logic [2*DW-1:0] fft_d14;
  logic [2*DW-1:0] fft_d15;
  logic          done;
  logic [3:0]    freq;
  logic          busy;
  logic          drop;

  modport master (
    output fft_valid,
    output fft_d0, fft_d1, fft_d2, fft_d3,
    output fft_d4, fft_d5, fft_d6, fft_d7,
    output fft_d8, fft_d9, fft_d10, fft_d11,
    output fft_d12, fft_d13, fft_d14, fft_d15,
    input  done, freq, busy, drop
  );

  modport slave (
    input  fft_valid,
    input  fft_d0, fft_d1, fft_d2, fft_d3,
    input  fft_d4, fft_d5, fft_d6, fft_d7,
    input  fft_d8, fft_d9, fft_d10, fft_d11,
    input  fft_d12, fft_d13, fft_d14, fft_d15,
    output done, freq, busy, drop
  );
endinterface

// File: rtl/fft_peak_analyzer.sv
// fft_peak_analyzer: captures a 16-bin spectrum and scans one bin per clock
// for the max re^2+im^2. Ports: clk, rst (async active-low), bus (slave).
module fft_peak_analyzer #(
  parameter int BINS = 16,
  parameter int DW   = 16
) (
  input logic clk,
  input logic rst,
  fft_peak_analyzer_if.slave bus
);
  localparam int IW = $clog2(BINS);
  localparam int WW = 2 * DW;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t state;
  state_t state_n;

  logic [WW-1:0] din   [BINS];
  logic [WW-1:0] frame [BINS];

  logic [IW-1:0] idx;
  logic [IW-1:0] max_idx;
  logic [IW-1:0] freq_q;
  logic [31:0]   max_pow;
  logic          drop_q;

  logic          capture;
  logic          last;
  logic          win;
  logic signed [WW-1:0] re;
  logic signed [WW-1:0] im;
  logic signed [WW-1:0] re_sq;
  logic signed [WW-1:0] im_sq;
  logic [31:0]   pow;

  assign din[0]  = bus.fft_d0;
  assign din[1]  = bus.fft_d1;
  assign din[2]  = bus.fft_d2;
  assign din[3]  = bus.fft_d3;
  assign din[4]  = bus.fft_d4;
  assign din[5]  = bus.fft_d5;
  assign din[6]  = bus.fft_d6;
  assign din[7]  = bus.fft_d7;
  assign din[8]  = bus.fft_d8;
  assign din[9]  = bus.fft_d9;
  assign din[10] = bus.fft_d10;
  assign din[11] = bus.fft_d11;
  assign din[12] = bus.fft_d12;
  assign din[13] = bus.fft_d13;
  assign din[14] = bus.fft_d14;
  assign din[15] = bus.fft_d15;

  assign capture = bus.fft_valid && (state != SCAN);
  assign last    = (idx == IW'(BINS - 1));

  // Sign-extend so each square is exact; both squares run in parallel.
  assign re = {{DW{frame[idx][WW-1]}}, frame[idx][WW-1:DW]};
  assign im = {{DW{frame[idx][DW-1]}}, frame[idx][DW-1:0]};
  assign re_sq = re * re;
  assign im_sq = im * im;
  assign pow = $unsigned(re_sq) + $unsigned(im_sq);
  assign win = (pow > max_pow);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (bus.fft_valid) state_n = SCAN;
      SCAN: if (last) state_n = DONE;
      DONE: state_n = bus.fft_valid ? SCAN : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Frame buffer contents are don't-care out of reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      frame <= din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx     <= '0;
      max_idx <= '0;
      max_pow <= '0;
      freq_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      // A strobe on the final scan edge lands in the done cycle;
      // it is discarded without a drop pulse so drop never meets done.
      drop_q <= bus.fft_valid && (state == SCAN) && !last;
      if (capture) begin
        idx     <= '0;
        max_idx <= '0;
        max_pow <= '0;
      end else if (state == SCAN) begin
        if (win) begin
          max_pow <= pow;
          max_idx <= idx;
        end
        if (last) begin
          freq_q <= win ? idx : max_idx;
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

  assign bus.done = (state == DONE);
  assign bus.busy = (state == SCAN);
  assign bus.drop = drop_q;
  assign bus.freq = freq_q;
endmodule
